// File: rtl/relu_fc_pkg.sv
// relu_fc_pkg: reduction mode type and width-generic ReLU / saturation helpers
package relu_fc_pkg;
  typedef enum logic {RM_MAX, RM_SUM} relu_mode_e;
  localparam int MAX_W = 64;
  localparam int MAX_LW = $clog2(MAX_W);
  // Callers zero-extend their operand to MAX_W; width names the real signed width
  function automatic logic [MAX_W-1:0] relu(input logic [MAX_W-1:0] value, input int width);
    return value[MAX_LW'(width - 1)] ? '0 : value;
  endfunction
  function automatic logic [MAX_W-1:0] sat_clamp(input logic [MAX_W-1:0] value, input int width);
    logic [MAX_W-1:0] lim;
    lim = (MAX_W'(1) << (width - 1)) - MAX_W'(1);
    return value > lim ? lim : value;
  endfunction
endpackage

// File: rtl/relu_group_acc.sv
// relu_group_acc: ReLU followed by max or saturating-sum reduction over GROUP samples
module relu_group_acc import relu_fc_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int GROUP = 4,
  parameter relu_mode_e MODE = RM_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              accept,
  input  logic [DATA_W-1:0] sample,
  output logic              elem_done,
  output logic [DATA_W-1:0] value,
  output logic              sat
);
  localparam int AW = DATA_W + $clog2(GROUP);
  localparam int CW = GROUP > 1 ? $clog2(GROUP) : 1;
  logic [AW-1:0] acc, r, nxt;
  logic [MAX_W-1:0] clamped;
  logic [CW-1:0] elem;
  // All operands are non-negative after ReLU, so unsigned compare/add is exact
  always_comb begin
    r = AW'(relu(MAX_W'(sample), DATA_W));
    nxt = elem == '0 ? r : MODE == RM_SUM ? acc + r : (acc > r ? acc : r);
    clamped = sat_clamp(MAX_W'(nxt), DATA_W);
    sat = MODE == RM_SUM && clamped != MAX_W'(nxt);
    value = DATA_W'(clamped);
    elem_done = accept && elem == CW'(GROUP - 1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      elem <= '0;
    end else if (clr) begin
      acc <= '0;
      elem <= '0;
    end else if (accept) begin
      acc <= nxt;
      elem <= elem_done ? '0 : elem + CW'(1);
    end
endmodule

// File: rtl/relu_pool_fc_buf.sv
// relu_pool_fc_buf: ReLU + group reduction packed into double-buffered parallel frames
module relu_pool_fc_buf import relu_fc_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int NUM_OUT = 128,
  parameter int GROUP = 4,
  parameter relu_mode_e MODE = RM_MAX
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      valid_in,
  output logic                      in_ready,
  output logic [NUM_OUT*DATA_W-1:0] data_out,
  output logic                      valid_out,
  input  logic                      out_ready,
  output logic                      sat_flag
);
  localparam int IW = $clog2(NUM_OUT);
  logic [DATA_W-1:0] bank [2][NUM_OUT];
  logic [1:0] full;
  logic wr_bank, rd_bank, accept, elem_done, sat, frame_done, rel_fire;
  logic [IW-1:0] out_idx;
  logic [DATA_W-1:0] value;
  if (NUM_OUT < 2 || GROUP < 1 || DATA_W + $clog2(GROUP) > MAX_W) begin : g_bad_cfg
    $fatal(1, "relu_pool_fc_buf: unsupported NUM_OUT/GROUP/DATA_W");
  end
  assign in_ready = !full[wr_bank] && !clr;
  assign accept = valid_in && in_ready;
  assign valid_out = full[rd_bank];
  assign rel_fire = valid_out && out_ready;
  assign frame_done = elem_done && out_idx == IW'(NUM_OUT - 1);
  relu_group_acc #(.DATA_W(DATA_W), .GROUP(GROUP), .MODE(MODE)) u_acc (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .accept(accept),
    .sample(data_in),
    .elem_done(elem_done),
    .value(value),
    .sat(sat)
  );
  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    assign data_out[k*DATA_W +: DATA_W] = bank[rd_bank][k];
  end
  // Completion only targets an empty bank and release only a full one, so they never collide
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bank <= '{default: '0};
      full <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      out_idx <= '0;
      sat_flag <= 1'b0;
    end else begin
      sat_flag <= elem_done && sat;
      if (elem_done) bank[wr_bank][out_idx] <= value;
      if (clr) out_idx <= '0;
      else if (elem_done) out_idx <= frame_done ? '0 : out_idx + IW'(1);
      if (frame_done) begin
        full[wr_bank] <= 1'b1;
        wr_bank <= !wr_bank;
      end
      if (rel_fire) begin
        full[rd_bank] <= 1'b0;
        rd_bank <= !rd_bank;
      end
    end
endmodule
